// File: rtl/clk_en_sched.sv
// Runtime-programmable divided-clock / clock-enable generator running on the system clk.
// Define CLK_SCHED_STATS_EN to add the 32-bit completed-period counter port period_cnt.
module clk_en_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic             en,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             running,
  output logic             cfg_err
`ifdef CLK_SCHED_STATS_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{period: CNT_W'(2), high: CNT_W'(1), phase: '0};

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] ph_q, ph_n;
  cfg_t             act_q, act_n;
  cfg_t             pend_q, pend_n;
  logic             pend_valid_q, pend_valid_n;
  logic             clk_n, rise_n, fall_n, err_n;

  cfg_t cfg_in;
  logic xfer, cfg_legal, load_now, store_pend, wrap;

  assign cfg_in     = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
  assign cfg_ready  = !pend_valid_q;
  assign running    = (state_q != IDLE);
  assign xfer       = cfg_valid && cfg_ready;
  assign cfg_legal  = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
  assign load_now   = xfer && cfg_legal && (state_q != RUN);
  assign store_pend = xfer && cfg_legal && (state_q == RUN);
  assign wrap       = (state_q == RUN) && (cnt_q == act_q.period - CNT_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_n      = state_q;
    cnt_n        = cnt_q;
    ph_n         = ph_q;
    act_n        = act_q;
    pend_n       = pend_q;
    pend_valid_n = pend_valid_q;

    if (load_now) act_n = cfg_in;
    // A word arriving on the wrap cycle is held for the next wrap, never applied now.
    if (store_pend) begin
      pend_n       = cfg_in;
      pend_valid_n = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_n = PHASE;
          ph_n    = load_now ? cfg_phase : act_q.phase;
        end
      end
      PHASE: begin
        if (!en) begin
          state_n = IDLE;
        end else if (load_now) begin
          ph_n = cfg_phase;
        end else if (ph_q == '0) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          ph_n = ph_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_n = '0;
          if (pend_valid_q) begin
            act_n        = pend_q;
            pend_valid_n = 1'b0;
          end
          if (!en) state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are computed from next-cycle state so clk_out is a clean flop output.
    clk_n  = (state_n == RUN) && (cnt_n < act_n.high);
    rise_n = clk_n && !clk_out;
    fall_n = !clk_n && clk_out;
    err_n  = xfer && !cfg_legal;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ph_q         <= '0;
      act_q        <= CFG_RST;
      pend_q       <= CFG_RST;
      pend_valid_q <= 1'b0;
      clk_out      <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      ph_q         <= ph_n;
      act_q        <= act_n;
      pend_q       <= pend_n;
      pend_valid_q <= pend_valid_n;
      clk_out      <= clk_n;
      rise_pulse   <= rise_n;
      fall_pulse   <= fall_n;
      cfg_err      <= err_n;
    end
  end

`ifdef CLK_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    period_cnt <= '0;
    else if (wrap) period_cnt <= period_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed self-checking bench for clk_en_sched; checks each cycle against hand-derived waveforms.
// Define CLK_SCHED_STATS_EN to also exercise period_cnt.
module tb_clk_en_sched;
  localparam int CNT_W = 16;

  logic             clk, rst_n, cfg_valid, cfg_ready, en;
  logic [CNT_W-1:0] cfg_period, cfg_high, cfg_phase;
  logic             clk_out, rise_pulse, fall_pulse, running, cfg_err;
`ifdef CLK_SCHED_STATS_EN
  logic [31:0]      period_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  clk_en_sched #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .en         (en),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .running    (running),
    .cfg_err    (cfg_err)
`ifdef CLK_SCHED_STATS_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int h, input int ph);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_phase  = CNT_W'(ph);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // One-cycle transfer while idle; cfg_ready is 1 there.
  task automatic load_cfg(input int p, input int h, input int ph);
    set_cfg(p, h, ph);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
    set_cfg(0, 0, 0);
    #2;
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_rise", rise_pulse, 1'b0);
    check("rst_fall", fall_pulse, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();

    // {10,1,2}: three PHASE cycles, then one high cycle every 10.
    load_cfg(10, 1, 2);
    check("t1_cfg_err", cfg_err, 1'b0);
    en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("t1_running", running, 1'b1);
      check("t1_clk_out", clk_out, (i >= 4) && ((i - 4) % 10 == 0));
      check("t1_rise", rise_pulse, (i >= 4) && ((i - 4) % 10 == 0));
      check("t1_fall", fall_pulse, (i >= 5) && ((i - 5) % 10 == 0));
    end

    // {10,5,0} running, {4,2,0} sent at cnt=3; applied at the wrap.
    do_reset();
    load_cfg(10, 5, 0);
    en = 1'b1;
    for (int j = 1; j <= 23; j++) begin
      tick();
      if (j == 6) cfg_valid = 1'b0;
      check("t2_clk_out", clk_out,
            (j < 2) ? 1'b0 : (j < 12) ? ((j - 2) < 5) : (((j - 12) % 4) < 2));
      check("t2_cfg_ready", cfg_ready, !(j >= 6 && j <= 11));
      if (j == 5) begin
        set_cfg(4, 2, 0);
        cfg_valid = 1'b1;
      end
    end

    // Illegal words: one cfg_err pulse each, waveform unchanged.
    set_cfg(5, 5, 0);
    cfg_valid = 1'b1;
    for (int j = 24; j <= 35; j++) begin
      tick();
      cfg_valid = 1'b0;
      check("t3_cfg_err", cfg_err, (j == 24) || (j == 28));
      check("t3_cfg_ready", cfg_ready, 1'b1);
      check("t3_clk_out", clk_out, ((j - 12) % 4) < 2);
      if (j == 27) begin
        set_cfg(1, 0, 0);
        cfg_valid = 1'b1;
      end
    end

    // Largest legal period is accepted; then stop mid-period of {8,4,0}.
    do_reset();
    load_cfg(65535, 65534, 0);
    check("t4_max_cfg_err", cfg_err, 1'b0);
    load_cfg(8, 4, 0);
    en = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      check("t4_clk_out", clk_out, (j >= 2) && (j <= 5));
      check("t4_running", running, j <= 9);
      check("t4_rise", rise_pulse, j == 2);
      check("t4_fall", fall_pulse, j == 6);
      if (j == 5) en = 1'b0;
    end

    // Async reset mid-high with a pending word; default {2,1,0} afterwards.
    do_reset();
    load_cfg(10, 5, 0);
    en = 1'b1;
    tick();
    tick();
    check("t5_rise_pre", rise_pulse, 1'b1);
    set_cfg(4, 2, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("t5_pend_ready", cfg_ready, 1'b0);
    check("t5_high_pre", clk_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clk_out", clk_out, 1'b0);
    check("t5_async_running", running, 1'b0);
    check("t5_async_rise", rise_pulse, 1'b0);
    check("t5_async_fall", fall_pulse, 1'b0);
    check("t5_async_ready", cfg_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t5_post_running", running, 1'b1);
      check("t5_post_clk_out", clk_out, (k >= 2) && (k % 2 == 0));
    end

`ifdef CLK_SCHED_STATS_EN
    // {3,1,0}: wrap number n happens at j = 2 + 3n.
    do_reset();
    load_cfg(3, 1, 0);
    en = 1'b1;
    for (int j = 1; j <= 62; j++) begin
      tick();
      if (j == 61) check_w("t6_period_cnt_19", period_cnt, 32'd19);
      if (j == 62) check_w("t6_period_cnt_20", period_cnt, 32'd20);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
